mandel_scan_ctrl: RTL and testbench
===================================

Name: mandel_scan_ctrl

Overview:
Raster-scan initiator that drives the per-pixel Mandelbrot engine. It steps through every pixel of a 320x240 frame, issues a one-cycle calc strobe per pixel, waits for the engine's completion handshake, and captures the returned colour. It then emits one plot write per pixel to the VGA framebuffer write port. It sits between the zoom/offset control logic (start request) and the engine/VGA adapter.

Parameters:
H_RES, 320, pixels per line; the x counter wraps at H_RES-1.
V_RES, 240, lines per frame; the y counter wraps at V_RES-1.
TIMEOUT, 4100, maximum WAIT cycles per pixel. Used only with SCAN_TIMEOUT_EN. Must exceed max_iter+4.

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  request a full-frame redraw (level or pulse; sampled each cycle)
busy  out  1  high from the accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last pixel's plot
pix_x  out  10  engine x coordinate, held stable from ISSUE through CAPTURE
pix_y  out  10  engine y coordinate, held stable from ISSUE through CAPTURE
calc  out  1  one-cycle strobe to the engine
calc_done  in  1  engine idle with result valid; low while iterating
pix_colour  in  12  engine colour, valid when calc_done=1 after a calc
vga_x  out  9  framebuffer write x
vga_y  out  8  framebuffer write y
vga_colour  out  12  framebuffer write data
vga_plot  out  1  framebuffer write enable, one cycle per pixel

Behaviour:
- Reset: state=IDLE. busy, frame_done, calc, vga_plot=0. pix_x, pix_y, vga_x, vga_y, vga_colour=0. pending=0. Reset wins over every other input in the same cycle.
- States: IDLE, ISSUE, ARM, WAIT, CAPTURE, PLOT, ADVANCE.
- IDLE: start=1 -> ISSUE with pix_x=pix_y=0 and busy=1.
- ISSUE: calc=1 for exactly one cycle -> ARM.
- ARM: wait for calc_done=0, i.e. the engine has accepted the request -> WAIT. This rejects a stale done from the previous pixel.
- WAIT: calc_done=1 -> CAPTURE.
- CAPTURE: register pix_colour into vga_colour; copy pix_x[8:0] and pix_y[7:0] into vga_x and vga_y -> PLOT.
- PLOT: vga_plot=1 for one cycle -> ADVANCE.
- ADVANCE, in priority order:
  - pending=1: clear pending, set pix_x=pix_y=0 -> ISSUE.
  - Last pixel (x=H_RES-1, y=V_RES-1): frame_done=1, busy=0 -> IDLE.
  - End of line (x=H_RES-1): x=0, y+1 -> ISSUE.
  - Otherwise: x+1 -> ISSUE.
- Minimum latency per pixel: 5 cycles plus engine iteration time.
- start while busy sets pending (sticky). The current pixel always completes its plot, then the scan restarts at (0,0). No partial-frame frame_done is issued.
- start in the same cycle as the last-pixel ADVANCE: frame_done still pulses, and the next frame begins at (0,0) without passing through an IDLE cycle.
- calc_done glitching high during ARM is ignored. Only a low-then-high sequence completes a pixel.
- pix_x and pix_y never exceed H_RES-1 and V_RES-1; no out-of-range plots.

Optional Feature:
Macro SCAN_TIMEOUT_EN.
- Defined: a 13-bit watchdog counts cycles spent in ARM+WAIT. On reaching TIMEOUT it forces CAPTURE with vga_colour=12'h000 and pulses an internal timeout flag (exported as port timeout_err, 1 bit, one-cycle pulse). The scan then continues normally.
- Not defined: no counter, no timeout_err port. ARM and WAIT wait indefinitely.

Decomposition:
- Shared package mandel_pkg: H_RES/V_RES defaults, coordinate widths (10/9/8), colour width 12, state enum encoding, black colour constant.
- One natural sub-module: scan_counter (x/y counter with wrap, last_pixel and end_of_line flags, clear and advance inputs). The FSM lives in mandel_scan_ctrl.

Test Plan:
- Reset then start pulse with an engine model that returns calc_done 3 cycles after calc and colour=x^y. Require exactly 76800 vga_plot pulses covering (0,0)..(319,239) in raster order, vga_colour matching the model, one frame_done, and busy low after it.
- Line wrap: at pixel (319,5), the next ISSUE has pix_x=0, pix_y=6. The plot at (319,5) precedes it.
- Stale done: calc_done held high through ISSUE and for 2 cycles into ARM, then low 4 cycles, then high. Require exactly one plot, and no plot before the low phase.
- Start mid-frame at pixel (100,20): pixel (100,20) is still plotted, the next calc has pix_x=pix_y=0, and no frame_done until the full restarted frame completes.
- Reset asserted during WAIT at (50,50): outputs return to reset values on the next edge, and no vga_plot is issued. A subsequent start begins at (0,0).
- With SCAN_TIMEOUT_EN and TIMEOUT=16: the engine never raises calc_done for pixel (7,0). After 16 cycles, timeout_err pulses, (7,0) is plotted with colour 000, and the scan continues at (8,0).

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot raster-scan controller: frame size, widths, FSM states.
// Latency: none, constants and types only.
// Backpressure: none.
package mandel_pkg;

    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;

    localparam int PIX_W   = 10;  // engine coordinate width
    localparam int VGA_X_W = 9;   // framebuffer x width
    localparam int VGA_Y_W = 8;   // framebuffer y width
    localparam int COL_W   = 12;  // colour width (4:4:4)

    localparam logic [COL_W-1:0] COL_BLACK = '0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_ARM     = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_PLOT    = 3'd5,
        S_ADVANCE = 3'd6
    } state_t;

endpackage

// File: rtl/scan_counter.sv
// Raster x/y pixel counter with end-of-line wrap and a last-pixel flag.
// Latency: clear/advance take effect on the next rising edge.
// Backpressure: none; counts only when advance is asserted, clear has priority.
module scan_counter
    import mandel_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [PIX_W-1:0] x,
    output logic [PIX_W-1:0] y,
    output logic             last_pixel
);

    localparam logic [PIX_W-1:0] X_LAST = PIX_W'(H_RES - 1);
    localparam logic [PIX_W-1:0] Y_LAST = PIX_W'(V_RES - 1);

    logic [PIX_W-1:0] x_q, x_d;
    logic [PIX_W-1:0] y_q, y_d;
    logic             end_of_line;

    assign end_of_line = (x_q == X_LAST);
    assign last_pixel  = end_of_line && (y_q == Y_LAST);

    // next coordinate: clear to origin, or step in raster order with wrap
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (end_of_line) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // coordinate registers
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/mandel_scan_ctrl.sv
// Raster-scan initiator: per pixel issues calc, waits for the engine handshake, then plots to the framebuffer.
// Latency: 5 cycles per pixel plus engine iteration time; frame_done pulses in the last pixel's ADVANCE cycle.
// Backpressure: stalls in ARM/WAIT on calc_done; a start while busy restarts after the current plot. SCAN_TIMEOUT_EN adds a watchdog.
module mandel_scan_ctrl
    import mandel_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
`ifdef SCAN_TIMEOUT_EN
    , parameter int TIMEOUT = 4100
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    output logic [PIX_W-1:0]   pix_x,
    output logic [PIX_W-1:0]   pix_y,
    output logic               calc,
    input  logic               calc_done,
    input  logic [COL_W-1:0]   pix_colour,
    output logic [VGA_X_W-1:0] vga_x,
    output logic [VGA_Y_W-1:0] vga_y,
    output logic [COL_W-1:0]   vga_colour,
    output logic               vga_plot
`ifdef SCAN_TIMEOUT_EN
    , output logic             timeout_err
`endif
);

    state_t             state_q, state_d;
    logic               pending_q, pending_d;
    logic [VGA_X_W-1:0] vga_x_q, vga_x_d;
    logic [VGA_Y_W-1:0] vga_y_q, vga_y_d;
    logic [COL_W-1:0]   vga_colour_q, vga_colour_d;
    logic               cnt_clear, cnt_adv, last_pixel, done_pulse;
    logic [COL_W-1:0]   cap_colour;

`ifdef SCAN_TIMEOUT_EN
    localparam logic [12:0] WD_LAST = 13'(TIMEOUT - 1);
    logic [12:0] wd_q, wd_d;
    logic        to_q, to_d;
`endif

    scan_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear),
        .advance    (cnt_adv),
        .x          (pix_x),
        .y          (pix_y),
        .last_pixel (last_pixel)
    );

    // next state, restart bookkeeping and counter control
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        cnt_clear  = 1'b0;
        cnt_adv    = 1'b0;
        done_pulse = 1'b0;
        // any start while a frame is in flight is remembered until ADVANCE
        if (start && state_q != S_IDLE) pending_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ISSUE;
                    cnt_clear = 1'b1;
                    pending_d = 1'b0;
                end
            end
            S_ISSUE:   state_d = S_ARM;
            // a done still high from the previous pixel must drop first
            S_ARM:     if (!calc_done) state_d = S_WAIT;
            S_WAIT:    if (calc_done) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_PLOT;
            S_PLOT:    state_d = S_ADVANCE;
            S_ADVANCE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    cnt_clear = 1'b1;
                    state_d   = S_ISSUE;
                end else if (last_pixel) begin
                    done_pulse = 1'b1;
                    cnt_clear  = 1'b1;
                    pending_d  = 1'b0;
                    // a start landing exactly here chains straight into the next frame
                    state_d    = start ? S_ISSUE : S_IDLE;
                end else begin
                    cnt_adv = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
`ifdef SCAN_TIMEOUT_EN
        wd_d = '0;
        to_d = 1'b0;
        if (state_q == S_ARM || state_q == S_WAIT) begin
            wd_d = wd_q + 1'b1;
            if (state_d != S_CAPTURE && wd_q == WD_LAST) begin
                state_d = S_CAPTURE;
                to_d    = 1'b1;
            end
        end
`endif
    end

`ifdef SCAN_TIMEOUT_EN
    assign cap_colour  = to_q ? COL_BLACK : pix_colour;
    assign timeout_err = to_q;
`else
    assign cap_colour  = pix_colour;
`endif

    // framebuffer write data latched once per pixel
    always_comb begin
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        if (state_q == S_CAPTURE) begin
            vga_x_d      = pix_x[VGA_X_W-1:0];
            vga_y_d      = pix_y[VGA_Y_W-1:0];
            vga_colour_d = cap_colour;
        end
    end

    // state and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
`ifdef SCAN_TIMEOUT_EN
            wd_q         <= '0;
            to_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
`ifdef SCAN_TIMEOUT_EN
            wd_q         <= wd_d;
            to_q         <= to_d;
`endif
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign calc       = (state_q == S_ISSUE);
    assign vga_plot   = (state_q == S_PLOT);
    assign frame_done = done_pulse;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Directed bench for mandel_scan_ctrl on a reduced 16x8 frame with a 3-cycle engine model.
// Latency: n/a.
// Backpressure: the engine model can stall a chosen pixel or be driven by hand.
module tb_mandel_scan_ctrl;

    localparam int H = 16;
    localparam int V = 8;
    localparam int NPIX = H * V;
    localparam int FRAME_BUDGET = NPIX * 12 + 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        calc_done = 1'b1;
    logic [11:0] pix_colour = '0;
    logic        busy, frame_done, calc, vga_plot;
    logic [9:0]  pix_x, pix_y;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [11:0] vga_colour;
`ifdef SCAN_TIMEOUT_EN
    logic        timeout_err;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct { int x; int y; int col; int c; } ev_t;
    ev_t plot_q[$];
    ev_t calc_q[$];
    int  fd_cnt = 0;
    int  fd_plots = 0;
    int  to_cnt = 0;

    bit  eng_en = 1'b1;
    int  hang_x = -1;
    int  hang_y = -1;
    int  ecnt = 0;

    mandel_scan_ctrl #(
        .H_RES(H),
        .V_RES(V)
`ifdef SCAN_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .calc       (calc),
        .calc_done  (calc_done),
        .pix_colour (pix_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
`ifdef SCAN_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    initial forever #5 clock = ~clock;
    initial forever @(posedge clock) cyc++;

    // event log, sampled on the falling edge
    initial forever begin
        @(negedge clock);
        if (vga_plot === 1'b1) plot_q.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour), cyc});
        if (calc === 1'b1) calc_q.push_back('{int'(pix_x), int'(pix_y), 0, cyc});
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_plots = plot_q.size();
        end
`ifdef SCAN_TIMEOUT_EN
        if (timeout_err === 1'b1) to_cnt++;
`endif
    end

    // engine model: done drops on calc, rises 3 cycles later, colour = x^y
    initial forever begin
        @(negedge clock);
        if (eng_en) begin
            if (calc === 1'b1) begin
                calc_done  = 1'b0;
                pix_colour = {2'b00, pix_x ^ pix_y};
                ecnt = (int'(pix_x) == hang_x && int'(pix_y) == hang_y) ? -1 : 3;
            end else if (ecnt > 0) begin
                ecnt--;
                if (ecnt == 0) calc_done = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_logs();
        plot_q.delete();
        calc_q.delete();
        fd_cnt = 0;
        fd_plots = 0;
        to_cnt = 0;
    endtask

    task automatic wait_calcs(input int n, input string nm);
        int k = 0;
        while (calc_q.size() < n && k < FRAME_BUDGET) begin tick(1); k++; end
        total++;
        if (calc_q.size() < n) begin
            bad++;
            $display("FAIL %s: calcs seen %0d, needed %0d", nm, calc_q.size(), n);
        end
    endtask

    task automatic wait_fd(input int n, input string nm);
        int k = 0;
        while (fd_cnt < n && k < 2 * FRAME_BUDGET) begin tick(1); k++; end
        total++;
        if (fd_cnt < n) begin
            bad++;
            $display("FAIL %s: frame_done count %0d, needed %0d", nm, fd_cnt, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total++;
        if ({busy, frame_done, calc, vga_plot} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctl: busy/fd/calc/plot=%b want 0000", {busy, frame_done, calc, vga_plot});
        end
        total++;
        if (pix_x !== 10'd0 || pix_y !== 10'd0) begin
            bad++;
            $display("FAIL reset_pix: got (%0d,%0d) want (0,0)", pix_x, pix_y);
        end
        total++;
        if (vga_x !== 9'd0 || vga_y !== 8'd0 || vga_colour !== 12'h000) begin
            bad++;
            $display("FAIL reset_vga: got (%0d,%0d,%h) want (0,0,000)", vga_x, vga_y, vga_colour);
        end
        reset = 1'b0;
        tick(3);
        total++;
        if (busy !== 1'b0 || calc !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_start: busy=%b calc=%b want 0 0", busy, calc);
        end
    endtask

    task automatic test_full_frame();
        int ord_err = 0;
        int col_err = 0;
        clear_logs();
        pulse_start();
        wait_fd(1, "full_done");
        tick(3);
        total++;
        if (plot_q.size() != NPIX) begin
            bad++;
            $display("FAIL full_plots: got %0d want %0d", plot_q.size(), NPIX);
        end
        for (int i = 0; i < plot_q.size() && i < NPIX; i++) begin
            if (plot_q[i].x != i % H || plot_q[i].y != i / H) ord_err++;
            if (plot_q[i].col != ((i % H) ^ (i / H))) col_err++;
        end
        total++;
        if (ord_err != 0) begin
            bad++;
            $display("FAIL full_order: %0d out-of-order plots, want 0", ord_err);
        end
        total++;
        if (col_err != 0) begin
            bad++;
            $display("FAIL full_colour: %0d wrong colours, want 0", col_err);
        end
        total++;
        if (fd_cnt != 1 || fd_plots != NPIX) begin
            bad++;
            $display("FAIL full_fd: count %0d after %0d plots, want 1 after %0d", fd_cnt, fd_plots, NPIX);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL full_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_line_wrap();
        clear_logs();
        pulse_start();
        wait_calcs(6 * H + 1, "wrap_reach");
        total++;
        if (calc_q.size() < 6 * H + 1 || plot_q.size() < 6 * H
            || calc_q[6 * H - 1].x != H - 1 || calc_q[6 * H - 1].y != 5
            || calc_q[6 * H].x != 0 || calc_q[6 * H].y != 6) begin
            bad++;
            $display("FAIL wrap_coord: calc after (%0d,5) not (0,6)", H - 1);
        end else if (plot_q[6 * H - 1].x != H - 1 || plot_q[6 * H - 1].y != 5
                     || plot_q[6 * H - 1].c >= calc_q[6 * H].c) begin
            bad++;
            $display("FAIL wrap_order: plot (%0d,%0d)@%0d want (%0d,5) before calc@%0d",
                     plot_q[6 * H - 1].x, plot_q[6 * H - 1].y, plot_q[6 * H - 1].c, H - 1, calc_q[6 * H].c);
        end
        wait_fd(1, "wrap_done");
        tick(2);
    endtask

    task automatic test_mid_start();
        localparam int IDX = 3 * H + 10;
        clear_logs();
        pulse_start();
        wait_calcs(IDX + 1, "mid_reach");
        pulse_start();
        wait_fd(1, "mid_done");
        tick(2);
        total++;
        if (plot_q.size() < IDX + 2 || plot_q[IDX].x != 10 || plot_q[IDX].y != 3
            || plot_q[IDX + 1].x != 0 || plot_q[IDX + 1].y != 0) begin
            bad++;
            $display("FAIL mid_plot: (10,3) not plotted then restart at (0,0), plots=%0d", plot_q.size());
        end
        total++;
        if (calc_q.size() < IDX + 2 || calc_q[IDX + 1].x != 0 || calc_q[IDX + 1].y != 0) begin
            bad++;
            $display("FAIL mid_calc: calc after (10,3) not at (0,0)");
        end
        total++;
        if (fd_cnt != 1 || fd_plots != IDX + 1 + NPIX) begin
            bad++;
            $display("FAIL mid_fd: count %0d after %0d plots, want 1 after %0d", fd_cnt, fd_plots, IDX + 1 + NPIX);
        end
    endtask

    task automatic test_stale_done();
        int k = 0;
        clear_logs();
        eng_en = 1'b0;
        calc_done = 1'b1;
        pix_colour = 12'hABC;
        pulse_start();
        while (calc_q.size() == 0 && k < 20) begin tick(1); k++; end
        tick(2);
        calc_done = 1'b0;
        tick(4);
        total++;
        if (plot_q.size() != 0) begin
            bad++;
            $display("FAIL stale_early: got %0d plots want 0", plot_q.size());
        end
        calc_done = 1'b1;
        tick(10);
        total++;
        if (plot_q.size() != 1) begin
            bad++;
            $display("FAIL stale_count: got %0d plots want 1", plot_q.size());
        end else if (plot_q[0].x != 0 || plot_q[0].y != 0 || plot_q[0].col != 12'hABC) begin
            bad++;
            $display("FAIL stale_data: got (%0d,%0d,%h) want (0,0,abc)", plot_q[0].x, plot_q[0].y, plot_q[0].col);
        end
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        eng_en = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_in_wait();
        int np;
        clear_logs();
        hang_x = 5;
        hang_y = 5;
        pulse_start();
        wait_calcs(5 * H + 6, "rst_reach");
        tick(3);
        total++;
        if (busy !== 1'b1 || calc_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_pre: busy=%b calc_done=%b want 1 0", busy, calc_done);
        end
        np = plot_q.size();
        reset = 1'b1;
        tick(1);
        total++;
        if ({busy, calc, vga_plot, frame_done} !== 4'b0000 || pix_x !== 10'd0 || pix_y !== 10'd0
            || vga_x !== 9'd0 || vga_y !== 8'd0 || vga_colour !== 12'h000) begin
            bad++;
            $display("FAIL rst_wait: ctl=%b pix=(%0d,%0d) vga=(%0d,%0d,%h) want all 0",
                     {busy, calc, vga_plot, frame_done}, pix_x, pix_y, vga_x, vga_y, vga_colour);
        end
        tick(2);
        reset = 1'b0;
        hang_x = -1;
        tick(2);
        total++;
        if (plot_q.size() != np) begin
            bad++;
            $display("FAIL rst_noplot: got %0d plots want %0d", plot_q.size(), np);
        end
        clear_logs();
        pulse_start();
        wait_calcs(1, "rst_restart");
        total++;
        if (calc_q.size() < 1 || calc_q[0].x != 0 || calc_q[0].y != 0) begin
            bad++;
            $display("FAIL rst_restart_xy: first calc not at (0,0)");
        end
        wait_fd(1, "rst_done");
        tick(2);
    endtask

    task automatic test_back_to_back();
        int k = 0;
        clear_logs();
        pulse_start();
        while (plot_q.size() < NPIX && k < FRAME_BUDGET) begin tick(1); k++; end
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        total++;
        if (fd_cnt != 1 || calc !== 1'b1 || busy !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
            bad++;
            $display("FAIL b2b_chain: fd=%0d calc=%b busy=%b pix=(%0d,%0d) want 1 1 1 (0,0)",
                     fd_cnt, calc, busy, pix_x, pix_y);
        end
        wait_fd(2, "b2b_done");
        tick(2);
        total++;
        if (plot_q.size() != 2 * NPIX || fd_plots != 2 * NPIX) begin
            bad++;
            $display("FAIL b2b_plots: got %0d (fd at %0d) want %0d", plot_q.size(), fd_plots, 2 * NPIX);
        end
    endtask

`ifdef SCAN_TIMEOUT_EN
    task automatic test_timeout();
        int k = 0;
        clear_logs();
        hang_x = 7;
        hang_y = 0;
        pulse_start();
        while (to_cnt == 0 && k < 300) begin tick(1); k++; end
        tick(4);
        total++;
        if (to_cnt != 1) begin
            bad++;
            $display("FAIL to_pulse: got %0d pulses want 1", to_cnt);
        end
        total++;
        if (plot_q.size() < 8 || plot_q[7].x != 7 || plot_q[7].y != 0 || plot_q[7].col != 0
            || plot_q[7].c - calc_q[7].c < 16) begin
            bad++;
            $display("FAIL to_plot: pixel (7,0) not plotted black after 16 cycles");
        end
        total++;
        if (calc_q.size() < 9 || calc_q[8].x != 8 || calc_q[8].y != 0) begin
            bad++;
            $display("FAIL to_next: scan did not continue at (8,0)");
        end
        hang_x = -1;
        wait_fd(1, "to_done");
        tick(2);
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_line_wrap();
        test_mid_start();
        test_stale_done();
        test_reset_in_wait();
        test_back_to_back();
`ifdef SCAN_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
